expr_result_misr: RTL and testbench
===================================

Name: expr_result_misr

Overview:
- Downstream consumer of the 90-bit result bus `y` produced by the vloghammer expression stage.
- Captures one 90-bit result per handshake and compresses it into a 32-bit multiple-input signature register (MISR).
- After a programmed number of samples it presents the final signature plus a golden-compare flag.
- Lets a regression run compare many expression evaluations against a single stored signature instead of per-vector dumps.

Parameters:
- Y_W, 90, width of the result bus consumed.
- SIG_W, 32, signature width.
- NUM_SAMPLES, 256, samples per run; legal range 1..65535.
- POLY, 32'h04C11DB7, MISR feedback polynomial.
- SEED, 32'h00000000, signature value loaded at run start.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins (or restarts) a run.
- in_valid  in  1  in_y holds a result this cycle.
- in_ready  out  1  block accepts in_y this cycle.
- in_y  in  90  result bus from the expression stage.
- expected_sig  in  32  golden signature; sampled only when DONE is entered.
- busy  out  1  high in RUN.
- sample_cnt  out  16  samples accepted in the current run.
- sig_valid  out  1  high in DONE.
- signature  out  32  current MISR contents.
- match  out  1  signature == expected_sig, latched on entry to DONE.

Behaviour:
- Reset is the only clocking exception: one clock, synchronous active-high reset.
  - Reset values: state IDLE, signature = SEED, sample_cnt = 0, in_ready = 0, busy = 0, sig_valid = 0, match = 0.
- States are IDLE, RUN and DONE.
  - IDLE -> RUN on start. This loads signature = SEED and sample_cnt = 0.
  - In RUN, in_ready = 1. An accept is in_valid && in_ready.
  - On each accept, signature <= step(signature, fold(in_y)) and sample_cnt += 1. Takes effect the next cycle.
  - When the accept brings sample_cnt to NUM_SAMPLES, next state is DONE. No further accepts.
  - DONE holds signature and sample_cnt. sig_valid = 1; match = (final signature == expected_sig), evaluated once on the DONE entry edge.
  - DONE -> RUN on start, with SEED reload, sample_cnt = 0, sig_valid = 0, match = 0.
- Fold: fold = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]}.
- Step: step = {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold.
- Outputs in_ready, busy and sig_valid are registered state decodes. They do not combinationally depend on in_valid.
- Latency: the signature reflects an accepted sample one cycle after the accept. sig_valid rises the cycle after the final accept.
- Back-pressure: in_valid low in RUN means the state is held and nothing changes. There is no timeout.
- start while in RUN restarts the run: SEED reload, count 0. Any in_y accepted in that same cycle is discarded.
- start and reset together: reset wins.
- Reset mid-run: everything returns to reset values and the partial signature is lost.
- Boundaries:
  - NUM_SAMPLES = 1: DONE is entered after the first accept.
  - sample_cnt never wraps. It saturates at NUM_SAMPLES because accepts stop.
- Arithmetic is unsigned, with no sign extension of in_y segments.

Test Plan:
- Reset, then start. in_valid held with in_y = 0 for 256 cycles -> signature = 0, sample_cnt = 256, sig_valid = 1 one cycle after the last accept. With expected_sig = 0, match = 1.
- NUM_SAMPLES = 2, SEED = 0. Accept y = 90'h1, then y = 0 -> signature 1 after the first accept, 2 after the second. sig_valid = 1, and match = 0 when expected_sig = 3.
- NUM_SAMPLES = 1, SEED = 0, y = all ones -> fold = 32'h03FFFFFF, so signature = 32'h03FFFFFF. Separately, y with only bit 32 set -> signature = 1. Separately, SEED = 32'h80000000 with y = 0 -> signature = 32'h04C11DB7.
- Random in_valid gaps (about 50%) over 256 samples -> final signature identical to the gap-free run of the same data. in_ready is never asserted in IDLE or DONE.
- start pulsed mid-run after 10 accepts, concurrent with an in_valid -> sample_cnt = 0 and signature = SEED next cycle, the concurrent sample is dropped, and the run then completes normally.
- reset asserted at sample 100 with start high in the same cycle -> all outputs at reset values next cycle, state IDLE, in_ready = 0.

Source files
------------

// File: rtl/expr_result_misr.sv
// expr_result_misr: compresses a stream of 90-bit expression results into a
// 32-bit multiple-input signature register and compares the final value with
// a golden signature once the programmed number of samples has been taken.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   start           pulse that begins or restarts a run
//   in_valid/in_ready/in_y   result input handshake
//   expected_sig    golden signature, sampled on entry to DONE
//   busy            high while a run is collecting samples
//   sample_cnt      samples accepted in the current run
//   sig_valid       high once the run has completed
//   signature       current MISR contents
//   match           final signature equals expected_sig
module expr_result_misr #(
   parameter int unsigned        Y_W         = 90,
   parameter int unsigned        SIG_W       = 32,
   parameter int unsigned        NUM_SAMPLES = 256,
   parameter logic [SIG_W-1:0]   POLY        = 32'h04C11DB7,
   parameter logic [SIG_W-1:0]   SEED        = 32'h00000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [Y_W-1:0]   in_y,
   input  logic [SIG_W-1:0] expected_sig,
   output logic             busy,
   output logic [15:0]      sample_cnt,
   output logic             sig_valid,
   output logic [SIG_W-1:0] signature,
   output logic             match
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SIG_W-1:0]   sig_q, sig_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               match_q, match_d;
   logic               in_ready_q, in_ready_d;
   logic               busy_q, busy_d;
   logic               sig_valid_q, sig_valid_d;

   logic [SIG_W-1:0]   fold_c;
   logic [SIG_W-1:0]   sig_step_c;
   logic [CNT_W-1:0]   cnt_inc_c;
   logic               accept_c;

   // Fold the result bus into one signature-wide word; the top segment is zero-extended.
   always_comb begin
      fold_c = in_y[SIG_W-1:0]
             ^ in_y[2*SIG_W-1:SIG_W]
             ^ SIG_W'(in_y[Y_W-1:2*SIG_W]);
   end

   // One MISR shift with polynomial feedback, then inject the folded sample.
   always_comb begin
      sig_step_c = {sig_q[SIG_W-2:0], 1'b0}
                 ^ (sig_q[SIG_W-1] ? POLY : '0)
                 ^ fold_c;
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      sig_d     = sig_q;
      cnt_d     = cnt_q;
      match_d   = match_q;
      accept_c  = in_ready_q && in_valid;
      cnt_inc_c = cnt_q + CNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               sig_d   = SEED;
               cnt_d   = '0;
               match_d = 1'b0;
            end
         end
         ST_RUN: begin
            // A restart wins over a sample accepted in the same cycle.
            if (start) begin
               sig_d   = SEED;
               cnt_d   = '0;
               match_d = 1'b0;
            end else if (accept_c) begin
               sig_d = sig_step_c;
               cnt_d = cnt_inc_c;
               if (cnt_inc_c == CNT_LAST) begin
                  state_d = ST_DONE;
                  match_d = (sig_step_c == expected_sig);
               end
            end
         end
         ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               sig_d   = SEED;
               cnt_d   = '0;
               match_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sig_d   = SEED;
            cnt_d   = '0;
            match_d = 1'b0;
         end
      endcase

      // Status outputs are registered decodes of the next state.
      in_ready_d  = (state_d == ST_RUN);
      busy_d      = (state_d == ST_RUN);
      sig_valid_d = (state_d == ST_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         sig_q       <= SEED;
         cnt_q       <= '0;
         match_q     <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         sig_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sig_q       <= sig_d;
         cnt_q       <= cnt_d;
         match_q     <= match_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         sig_valid_q <= sig_valid_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign busy       = busy_q;
   assign sample_cnt = cnt_q;
   assign sig_valid  = sig_valid_q;
   assign signature  = sig_q;
   assign match      = match_q;

endmodule

// File: tb/tb_expr_result_misr.sv
// Bench for expr_result_misr: four instances with different sample counts and
// seeds share one input stream and are compared every cycle against a
// transaction-level reference, plus directed signature values.
module tb_expr_result_misr;

   localparam int unsigned NI = 4;
   localparam int unsigned NS [NI] = '{256, 2, 1, 1};
   localparam logic [31:0] SD [NI] = '{32'h0, 32'h0, 32'h0, 32'h80000000};
   localparam logic [31:0] POLY = 32'h04C11DB7;

   logic        clk = 1'b0;
   logic        reset, start, in_valid;
   logic [89:0] in_y;
   logic [31:0] expected_sig;

   logic        in_ready_o  [NI];
   logic        busy_o      [NI];
   logic [15:0] cnt_o       [NI];
   logic        sig_valid_o [NI];
   logic [31:0] sig_o       [NI];
   logic        match_o     [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      expr_result_misr #(
         .Y_W(90), .SIG_W(32), .NUM_SAMPLES(NS[g]), .POLY(POLY), .SEED(SD[g])
      ) u_dut (
         .clk(clk), .reset(reset), .start(start),
         .in_valid(in_valid), .in_ready(in_ready_o[g]), .in_y(in_y),
         .expected_sig(expected_sig), .busy(busy_o[g]),
         .sample_cnt(cnt_o[g]), .sig_valid(sig_valid_o[g]),
         .signature(sig_o[g]), .match(match_o[g])
      );
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference: XOR of 32-bit chunks, then multiply-by-x modulo the polynomial.
   function automatic logic [31:0] fold_ref(input logic [89:0] y);
      logic [31:0] acc = '0;
      for (int k = 0; k < 3; k++) acc ^= 32'(y >> (32 * k));
      return acc;
   endfunction

   function automatic logic [31:0] step_ref(input logic [31:0] s, input logic [89:0] y);
      logic [32:0] w;
      w = {s, 1'b0};
      if (w[32]) w ^= {1'b1, POLY};
      return w[31:0] ^ fold_ref(y);
   endfunction

   logic [89:0] ydat [256];

   function automatic logic [31:0] run_ref(input logic [31:0] seed);
      logic [31:0] s = seed;
      for (int k = 0; k < 256; k++) s = step_ref(s, ydat[k]);
      return s;
   endfunction

   // Per-instance transaction model: 0 idle, 1 collecting, 2 complete.
   int          m_st    [NI];
   logic [31:0] m_sig   [NI];
   int          m_cnt   [NI];
   bit          m_match [NI];

   task automatic model_update();
      for (int i = 0; i < NI; i++) begin
         if (reset) begin
            m_st[i] = 0; m_sig[i] = SD[i]; m_cnt[i] = 0; m_match[i] = 0;
         end else if (start) begin
            m_st[i] = 1; m_sig[i] = SD[i]; m_cnt[i] = 0; m_match[i] = 0;
         end else if (m_st[i] == 1 && in_valid) begin
            m_sig[i] = step_ref(m_sig[i], in_y);
            m_cnt[i]++;
            if (m_cnt[i] == int'(NS[i])) begin
               m_st[i] = 2;
               m_match[i] = (m_sig[i] == expected_sig);
            end
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < NI; i++) begin
         check_eq($sformatf("sig[%0d]", i),       64'(sig_o[i]),       64'(m_sig[i]));
         check_eq($sformatf("cnt[%0d]", i),       64'(cnt_o[i]),       64'(m_cnt[i]));
         check_eq($sformatf("ready[%0d]", i),     64'(in_ready_o[i]),  64'(m_st[i] == 1));
         check_eq($sformatf("busy[%0d]", i),      64'(busy_o[i]),      64'(m_st[i] == 1));
         check_eq($sformatf("sig_valid[%0d]", i), 64'(sig_valid_o[i]), 64'(m_st[i] == 2));
         check_eq($sformatf("match[%0d]", i),     64'(match_o[i]),     64'(m_match[i]));
      end
   endtask

   task automatic cyc(input bit r, input bit s, input bit v, input logic [89:0] y);
      reset = r; start = s; in_valid = v; in_y = y;
      @(posedge clk);
      model_update();
      #1;
      check_all();
   endtask

   function automatic logic [89:0] rand_y();
      return {26'($urandom), $urandom, $urandom};
   endfunction

   logic [89:0] ones;
   logic [89:0] bit32;
   logic [31:0] gold;
   int          idx;
   int          guard;
   bit          v;

   initial begin
      ones  = '1;
      bit32 = 90'(1) << 32;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_y = '0; expected_sig = '0;
      for (int k = 0; k < 256; k++) ydat[k] = rand_y();

      // Reset values
      cyc(1, 0, 0, '0);
      cyc(1, 0, 0, '0);
      check_eq("rst_sig",   64'(sig_o[0]),      64'h0);
      check_eq("rst_ready", 64'(in_ready_o[0]), 64'h0);
      check_eq("rst_cnt",   64'(cnt_o[0]),      64'h0);
      cyc(0, 0, 1, rand_y());
      check_eq("idle_ready", 64'(in_ready_o[0]), 64'h0);

      // All-zero run of 256 samples
      expected_sig = 32'h0;
      cyc(0, 1, 0, '0);
      repeat (255) cyc(0, 0, 1, '0);
      check_eq("zero_not_done", 64'(sig_valid_o[0]), 64'h0);
      cyc(0, 0, 1, '0);
      check_eq("zero_sig",   64'(sig_o[0]),       64'h0);
      check_eq("zero_cnt",   64'(cnt_o[0]),       64'd256);
      check_eq("zero_valid", 64'(sig_valid_o[0]), 64'h1);
      check_eq("zero_match", 64'(match_o[0]),     64'h1);
      cyc(0, 0, 1, ones);
      check_eq("done_hold_cnt", 64'(cnt_o[0]), 64'd256);

      // Two-sample run: 1 then 0
      expected_sig = 32'h3;
      cyc(0, 1, 0, '0);
      cyc(0, 0, 1, 90'h1);
      check_eq("n2_sig1", 64'(sig_o[1]), 64'h1);
      cyc(0, 0, 1, '0);
      check_eq("n2_sig2",   64'(sig_o[1]),       64'h2);
      check_eq("n2_valid",  64'(sig_valid_o[1]), 64'h1);
      check_eq("n2_match",  64'(match_o[1]),     64'h0);

      // Single-sample runs
      cyc(0, 1, 0, '0);
      cyc(0, 0, 1, ones);
      check_eq("n1_ones", 64'(sig_o[2]), 64'h03FFFFFF);
      check_eq("n1_done", 64'(sig_valid_o[2]), 64'h1);
      cyc(0, 1, 0, '0);
      cyc(0, 0, 1, bit32);
      check_eq("n1_bit32", 64'(sig_o[2]), 64'h1);
      cyc(0, 1, 0, '0);
      cyc(0, 0, 1, '0);
      check_eq("n1_seed_msb", 64'(sig_o[3]), 64'h04C11DB7);

      // Random data, gap-free
      gold = run_ref(32'h0);
      expected_sig = gold;
      cyc(0, 1, 0, '0);
      for (int k = 0; k < 256; k++) cyc(0, 0, 1, ydat[k]);
      check_eq("rand_nogap_sig",   64'(sig_o[0]),   64'(gold));
      check_eq("rand_nogap_match", 64'(match_o[0]), 64'h1);

      // Same data with ~50% valid gaps
      cyc(0, 1, 0, '0);
      idx = 0; guard = 0;
      while (idx < 256 && guard < 4000) begin
         v = 1'($urandom_range(0, 1));
         cyc(0, 0, v, v ? ydat[idx] : rand_y());
         if (v) idx++;
         guard++;
      end
      check_eq("gap_budget", 64'(idx), 64'd256);
      check_eq("rand_gap_sig",   64'(sig_o[0]),       64'(gold));
      check_eq("rand_gap_valid", 64'(sig_valid_o[0]), 64'h1);

      // Restart mid-run, concurrent sample dropped
      cyc(0, 1, 0, '0);
      for (int k = 0; k < 10; k++) cyc(0, 0, 1, rand_y());
      cyc(0, 1, 1, rand_y());
      check_eq("restart_cnt", 64'(cnt_o[0]), 64'h0);
      check_eq("restart_sig", 64'(sig_o[0]), 64'h0);
      for (int k = 0; k < 256; k++) cyc(0, 0, 1, ydat[k]);
      check_eq("restart_final", 64'(sig_o[0]),   64'(gold));
      check_eq("restart_match", 64'(match_o[0]), 64'h1);

      // Reset with start at sample 100
      cyc(0, 1, 0, '0);
      for (int k = 0; k < 100; k++) cyc(0, 0, 1, ydat[k]);
      cyc(1, 1, 1, rand_y());
      check_eq("midrst_sig",   64'(sig_o[0]),       64'h0);
      check_eq("midrst_cnt",   64'(cnt_o[0]),       64'h0);
      check_eq("midrst_ready", 64'(in_ready_o[0]),  64'h0);
      check_eq("midrst_busy",  64'(busy_o[0]),      64'h0);
      check_eq("midrst_valid", 64'(sig_valid_o[0]), 64'h0);
      check_eq("midrst_match", 64'(match_o[0]),     64'h0);
      cyc(0, 0, 1, rand_y());
      check_eq("midrst_idle", 64'(in_ready_o[0]), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
